// File: rtl/vga_window_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_window_gen: parametrised VGA timing, upscaled frame-buffer window and   |
// | read-latency compensation. Optional border ring: VGA_WIN_BORDER_EN.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vga_window_gen #(
    parameter int   H_ACT  = 640,
    parameter int   H_FP   = 16,
    parameter int   H_SYNC = 96,
    parameter int   H_BP   = 48,
    parameter int   V_ACT  = 480,
    parameter int   V_FP   = 10,
    parameter int   V_SYNC = 2,
    parameter int   V_BP   = 33,
    parameter logic HS_POL = 1'b0,
    parameter logic VS_POL = 1'b0,
    parameter int   WIN_X  = 160,
    parameter int   WIN_Y  = 120,
    parameter int   WIN_W  = 320,
    parameter int   WIN_H  = 240,
    parameter int   SCALE  = 1,
    parameter int   ADDR_W = 17,
    parameter int   RD_LAT = 1
) (
    input  logic              clk25,
    input  logic              rst_n,
    input  logic              pix_mode,
    output logic [ADDR_W-1:0] frame_addr,
    input  logic [11:0]       frame_pixel,
    output logic [3:0]        vga_red,
    output logic [3:0]        vga_green,
    output logic [3:0]        vga_blue,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic [9:0]        HCnt,
    output logic [9:0]        VCnt,
    output logic              frame_start,
    output logic              in_window
);
    localparam int c_h_tot  = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int c_v_tot  = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int c_pipe   = RD_LAT + 1;
    localparam int c_win_xe = WIN_X + WIN_W * SCALE;
    localparam int c_win_ye = WIN_Y + WIN_H * SCALE;
    localparam int c_hs_beg = H_ACT + H_FP;
    localparam int c_vs_beg = V_ACT + V_FP;
    localparam int c_b_fs   = 20;
    localparam int c_b_win  = 21;
    localparam int c_b_vs   = 22;
    localparam int c_b_hs   = 23;
`ifdef VGA_WIN_BORDER_EN
    localparam int c_b_bdr  = 24;
    localparam int c_sb_w   = 25;
`else
    localparam int c_sb_w   = 24;
`endif

    logic [9:0]        r_h, r_v;
    logic [31:0]       w_hx, w_vx;
    logic              w_h_end, w_v_end, w_in_x, w_in_y, w_win, w_fs0, w_hs, w_vs;
    logic [2:0]        r_sx, r_sy;
    logic [ADDR_W-1:0] r_col, r_base, r_addr_hold, w_addr;
    logic              r_mode, w_pre_win;
    logic [11:0]       r_rgb;
    logic [c_sb_w-1:0] w_s0;
    logic [c_sb_w-1:0] r_pipe [c_pipe];

    assign w_hx    = {22'd0, r_h};
    assign w_vx    = {22'd0, r_v};
    assign w_h_end = (w_hx == 32'(c_h_tot - 1));
    assign w_v_end = (w_vx == 32'(c_v_tot - 1));
    assign w_in_x  = (w_hx >= 32'(WIN_X)) && (w_hx < 32'(c_win_xe)) && (w_hx < 32'(H_ACT));
    assign w_in_y  = (w_vx >= 32'(WIN_Y)) && (w_vx < 32'(c_win_ye)) && (w_vx < 32'(V_ACT));
    assign w_win   = w_in_x && w_in_y;
    assign w_fs0   = (r_h == 10'd0) && (r_v == 10'd0);
    assign w_hs    = (w_hx >= 32'(c_hs_beg)) && (w_hx < 32'(c_hs_beg + H_SYNC));
    assign w_vs    = (w_vx >= 32'(c_vs_beg)) && (w_vx < 32'(c_vs_beg + V_SYNC));

`ifdef VGA_WIN_BORDER_EN
    logic w_border, w_pre_bdr;
    // Ring one pixel outside the window; +1 keeps the left/top test unsigned-safe.
    assign w_border = (w_hx + 32'd1 >= 32'(WIN_X)) && (w_hx <= 32'(c_win_xe))
                   && (w_vx + 32'd1 >= 32'(WIN_Y)) && (w_vx <= 32'(c_win_ye))
                   && (w_hx < 32'(H_ACT)) && (w_vx < 32'(V_ACT)) && !w_win;
    assign w_s0 = {w_border, w_hs, w_vs, w_win, w_fs0, r_h, r_v};
`else
    assign w_s0 = {w_hs, w_vs, w_win, w_fs0, r_h, r_v};
`endif

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_end) begin
            r_h <= '0;
            r_v <= w_v_end ? 10'd0 : r_v + 10'd1;
        end else begin
            r_h <= r_h + 10'd1;
        end
    end

    // Divider-free addressing: sub-pixel/column counters plus a per-row base.
    assign w_addr     = r_base + r_col;
    assign frame_addr = w_win ? w_addr : r_addr_hold;

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            r_sx        <= '0;
            r_col       <= '0;
            r_sy        <= '0;
            r_base      <= '0;
            r_addr_hold <= '0;
        end else begin
            if (w_win) begin
                r_addr_hold <= w_addr;
                if (r_sx == 3'(SCALE - 1)) begin
                    r_sx  <= '0;
                    r_col <= r_col + ADDR_W'(1);
                end else begin
                    r_sx <= r_sx + 3'd1;
                end
            end else begin
                r_sx  <= '0;
                r_col <= '0;
            end
            if (w_h_end) begin
                if (w_v_end) begin
                    r_sy   <= '0;
                    r_base <= '0;
                end else if (w_in_y) begin
                    if (r_sy == 3'(SCALE - 1)) begin
                        r_sy   <= '0;
                        r_base <= r_base + ADDR_W'(WIN_W);
                    end else begin
                        r_sy <= r_sy + 3'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (!rst_n)
            r_mode <= 1'b0;
        else if (w_fs0)
            r_mode <= pix_mode;
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            for (int k = 0; k < c_pipe; k++) r_pipe[k] <= '0;
        end else begin
            r_pipe[0] <= w_s0;
            for (int k = 1; k < c_pipe; k++) r_pipe[k] <= r_pipe[k-1];
        end
    end

    // Colour gating uses the sideband delayed by RD_LAT, matching frame_pixel arrival.
    generate
        if (RD_LAT == 0) begin : g_pre_direct
            assign w_pre_win = w_win;
`ifdef VGA_WIN_BORDER_EN
            assign w_pre_bdr = w_border;
`endif
        end else begin : g_pre_piped
            assign w_pre_win = r_pipe[RD_LAT-1][c_b_win];
`ifdef VGA_WIN_BORDER_EN
            assign w_pre_bdr = r_pipe[RD_LAT-1][c_b_bdr];
`endif
        end
    endgenerate

    always_ff @(posedge clk25) begin
        if (!rst_n)
            r_rgb <= '0;
        else if (w_pre_win)
            r_rgb <= r_mode ? frame_pixel : {12{frame_pixel[0]}};
`ifdef VGA_WIN_BORDER_EN
        else if (w_pre_bdr)
            r_rgb <= 12'hFFF;
`endif
        else
            r_rgb <= '0;
    end

    assign {vga_red, vga_green, vga_blue} = r_rgb;
    assign vga_hsync   = r_pipe[c_pipe-1][c_b_hs] ? HS_POL : ~HS_POL;
    assign vga_vsync   = r_pipe[c_pipe-1][c_b_vs] ? VS_POL : ~VS_POL;
    assign HCnt        = r_pipe[c_pipe-1][19:10];
    assign VCnt        = r_pipe[c_pipe-1][9:0];
    assign frame_start = r_pipe[c_pipe-1][c_b_fs];
    assign in_window   = r_pipe[c_pipe-1][c_b_win];
endmodule
`default_nettype wire

// File: doc/vga_window_gen.md
Name: vga_window_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA display block.
- Generates VGA timing from parameters, with configurable sync polarity.
- Addresses a frame buffer window with integer upscaling and compensates for frame-buffer read latency, so sync and pixel data stay aligned.
- Pixel format is selectable at run time (mono or RGB444). Sits between the camera frame buffer read port and the VGA pins.

Parameters:
- H_ACT, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACT, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- WIN_X, 160, window left edge (screen pixels)
- WIN_Y, 120, window top edge (screen lines)
- WIN_W, 320, window width in source pixels
- WIN_H, 240, window height in source pixels
- SCALE, 1, integer upscale factor (1..4)
- ADDR_W, 17, frame_addr width
- RD_LAT, 1, frame buffer read latency in cycles (0..3)

Ports:
- clk25 in 1 pixel clock
- rst_n in 1 synchronous active-low reset
- pix_mode in 1 0 = mono (frame_pixel[0] replicated to all channels), 1 = RGB444 (R = [11:8], G = [7:4], B = [3:0])
- frame_addr out ADDR_W frame buffer read address
- frame_pixel in 12 read data, valid RD_LAT cycles after its address
- vga_red out 4 red channel
- vga_green out 4 green channel
- vga_blue out 4 blue channel
- vga_hsync out 1 horizontal sync
- vga_vsync out 1 vertical sync
- HCnt out 10 horizontal position aligned to the colour outputs
- VCnt out 10 vertical position aligned to the colour outputs
- frame_start out 1 one-cycle pulse aligned with output pixel (0,0)
- in_window out 1 high when the output pixel lies inside the window

Behaviour:
- Timing totals: H_TOT = H_ACT+H_FP+H_SYNC+H_BP; V_TOT likewise.
- Stage-0 counters h,v:
  - h increments every clk25 and wraps H_TOT-1 -> 0.
  - v increments on the h wrap and wraps V_TOT-1 -> 0.
- Stage-0 sync conditions:
  - hsync active while H_ACT+H_FP <= h < H_ACT+H_FP+H_SYNC.
  - vsync active while V_ACT+V_FP <= v < V_ACT+V_FP+V_SYNC.
- Window region:
  - win = (WIN_X <= h < WIN_X+WIN_W*SCALE) and (WIN_Y <= v < WIN_Y+WIN_H*SCALE), ANDed with the active area. Any part outside the active area is clipped.
- Address generation (no divider; uses sub-pixel and sub-line counters plus a line-base register):
  - frame_addr = ((v-WIN_Y)/SCALE)*WIN_W + (h-WIN_X)/SCALE.
  - Driven combinationally from stage-0 state; holds its last value outside the window.
  - Line base advances by WIN_W after every SCALE-th window line.
  - Line base resets to 0 at v = 0.
- Pipeline: sync, win, active and position are delayed by PIPE = RD_LAT+1 registers. Outputs are registered at the final stage.
- Output alignment: the colour for address A appears on vga_* exactly PIPE cycles after A is presented, together with that pixel's sync/HCnt/VCnt.
- Colour output: zero when the delayed win is 0 or outside the active area; otherwise decoded from frame_pixel per the latched mode.
- pix_mode latching: sampled into an internal register only when stage-0 h = 0 and v = 0. A mid-frame change takes effect at the next frame.
- frame_start: high for exactly one cycle when the output stage is at h = 0, v = 0.
- Reset (rst_n low at clk25 edge):
  - h, v, line base and sub-counters = 0.
  - frame_addr = 0; all pipeline stages cleared.
  - vga_red/green/blue = 0; vga_hsync = ~HS_POL; vga_vsync = ~VS_POL.
  - HCnt = VCnt = 0; frame_start = 0; in_window = 0; latched mode = 0.
  - Reset mid-frame restarts timing at (0,0). First frame_start occurs PIPE cycles after release.
- SCALE = 1 degenerates to a direct 1:1 window.
- Address never exceeds WIN_W*WIN_H-1.

Optional Feature:
VGA_WIN_BORDER_EN
- Defined: the one-pixel ring immediately outside the window (clipped to the active area) is driven white (4'hF on all channels). in_window stays 0 on the border.
- Undefined: border pixels are black like the rest of the non-window area. No border logic is synthesised.

Test Plan:
- Defaults, 2 frames:
  - hsync low for 96 cycles starting 656+PIPE cycles after line start.
  - vsync low on lines 490-491.
  - Line period 800 cycles, frame period 420000 cycles.
- Defaults, frame_pixel = frame_addr[11:0], pix_mode = 1:
  - Output pixel (160,120) shows addr 0; (479,120) shows addr 319; (160,121) shows addr 320; (479,359) shows addr 76799.
  - (159,120) and (480,120) are black.
- SCALE = 2, WIN_W = 160, WIN_H = 120: addr repeats twice per line and each address row repeats for 2 lines; last addr is 19199.
- pix_mode = 0, frame_pixel = 12'h001: window pixels = 4'hF on all channels. pix_mode toggled mid-frame: output changes only after the next frame_start.
- RD_LAT = 3: colour/sync alignment is preserved; frame_start is seen 4 cycles after the stage-0 (0,0).
- Assert rst_n low at line 200: all outputs take their reset values next edge; after release, counters restart at 0 and frame_addr is 0.
